// File: rtl/stall_ctrl_param.sv
// Pipeline stall controller: decodes the opcode field of the program-memory
// word and inserts a configurable number of stall bubbles for jumps and loads,
// enters a sticky halt, and freezes the bubble countdown while the external
// wait request is high. stall_pm is stall delayed by one clock.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | decoding ins_pm each edge (unless ext_stall is high)
// BUBBLE | counting down bub_cnt; stall held high
// HALT   | terminal; stall and halted high until reset
module stall_ctrl_param #(
    parameter int unsigned       INS_W       = 20,
    parameter int unsigned       OPC_MSB     = 19,
    parameter int unsigned       OPC_W       = 5,
    parameter logic [OPC_W-1:0]  HLT_MASK    = 5'b11110,
    parameter logic [OPC_W-1:0]  HLT_MATCH   = 5'b11110,
    parameter logic [OPC_W-1:0]  JMP_MASK    = 5'b11110,
    parameter logic [OPC_W-1:0]  JMP_MATCH   = 5'b10100,
    parameter logic [OPC_W-1:0]  LD_MASK     = 5'b11111,
    parameter logic [OPC_W-1:0]  LD_MATCH    = 5'b10001,
    parameter int unsigned       JMP_BUBBLES = 2,
    parameter int unsigned       LD_BUBBLES  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INS_W-1:0] ins_pm,
    input  logic             ext_stall,
    output logic             stall,
    output logic             stall_pm,
    output logic             halted,
    output logic [3:0]       bub_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUBBLE = 2'd1,
        S_HALT   = 2'd2
    } state_t;

    // A bubble count of zero disables that hazard class entirely.
    localparam bit         JMP_EN   = (JMP_BUBBLES > 0);
    localparam bit         LD_EN    = (LD_BUBBLES > 0);
    localparam logic [3:0] JMP_INIT = JMP_EN ? 4'(JMP_BUBBLES - 1) : 4'd0;
    localparam logic [3:0] LD_INIT  = LD_EN ? 4'(LD_BUBBLES - 1) : 4'd0;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       bub_nxt;
    logic             stall_nxt;
    logic [OPC_W-1:0] opc;
    logic             cls_hlt;
    logic             cls_jmp;
    logic             cls_ld;
    logic             ins_unused;

    assign opc     = ins_pm[OPC_MSB -: OPC_W];
    assign cls_hlt = ((opc & HLT_MASK) == HLT_MATCH);
    assign cls_jmp = ((opc & JMP_MASK) == JMP_MATCH);
    assign cls_ld  = ((opc & LD_MASK) == LD_MATCH);

    // Only the opcode field matters; the remaining bits are deliberately ignored.
    assign ins_unused = ^ins_pm;

    // State register plus the registered outputs and the one-cycle stall delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            stall    <= 1'b0;
            stall_pm <= 1'b0;
            bub_cnt  <= 4'd0;
        end else begin
            state    <= state_nxt;
            stall    <= stall_nxt;
            stall_pm <= stall;
            bub_cnt  <= bub_nxt;
        end
    end

    // Next-state decode: priority halt > jump > load, only in IDLE without ext_stall.
    always_comb begin
        state_nxt = state;
        bub_nxt   = bub_cnt;
        stall_nxt = stall;
        case (state)
            S_IDLE: begin
                bub_nxt   = 4'd0;
                stall_nxt = ext_stall;
                if (!ext_stall) begin
                    if (cls_hlt) begin
                        state_nxt = S_HALT;
                        stall_nxt = 1'b1;
                    end else if (cls_jmp && JMP_EN) begin
                        state_nxt = S_BUBBLE;
                        bub_nxt   = JMP_INIT;
                        stall_nxt = 1'b1;
                    end else if (cls_ld && LD_EN) begin
                        state_nxt = S_BUBBLE;
                        bub_nxt   = LD_INIT;
                        stall_nxt = 1'b1;
                    end
                end
            end
            S_BUBBLE: begin
                stall_nxt = 1'b1;
                if (!ext_stall) begin
                    if (bub_cnt == 4'd0) begin
                        state_nxt = S_IDLE;
                        stall_nxt = 1'b0;
                    end else begin
                        bub_nxt = bub_cnt - 4'd1;
                    end
                end
            end
            S_HALT: begin
                stall_nxt = 1'b1;
                bub_nxt   = 4'd0;
            end
            default: begin
                state_nxt = S_IDLE;
                stall_nxt = 1'b0;
                bub_nxt   = 4'd0;
            end
        endcase
    end

    // halted is a pure decode of the terminal state.
    always_comb begin
        halted = (state == S_HALT);
    end

endmodule

// File: tb/tb_stall_ctrl_param.sv
// Randomized bench for stall_ctrl_param: a default instance and an instance
// with JMP_BUBBLES=4, LD_BUBBLES=0 share the same stimulus and are compared
// cycle by cycle against a model that tracks owed stall cycles per instance.
module tb_stall_ctrl_param;

    logic        clk;
    logic        reset;
    logic [19:0] ins_pm;
    logic        ext_stall;
    logic        stall_o    [2];
    logic        stall_pm_o [2];
    logic        halted_o   [2];
    logic [3:0]  bub_o      [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: stall cycles still owed for the current hazard,
    // sticky halt flag, and the expected stall / stall_pm levels.
    int owed    [2];
    bit hlt_m   [2];
    bit stall_m [2];
    bit spm_m   [2];
    int jb_p    [2];
    int lb_p    [2];

    typedef struct {
        logic [19:0] ins;
        bit          ext;
    } vec_t;

    vec_t dir_q[$];

    stall_ctrl_param u_dut_def (
        .clk       (clk),
        .reset     (reset),
        .ins_pm    (ins_pm),
        .ext_stall (ext_stall),
        .stall     (stall_o[0]),
        .stall_pm  (stall_pm_o[0]),
        .halted    (halted_o[0]),
        .bub_cnt   (bub_o[0])
    );

    stall_ctrl_param #(
        .JMP_BUBBLES (4),
        .LD_BUBBLES  (0)
    ) u_dut_ovr (
        .clk       (clk),
        .reset     (reset),
        .ins_pm    (ins_pm),
        .ext_stall (ext_stall),
        .stall     (stall_o[1]),
        .stall_pm  (stall_pm_o[1]),
        .halted    (halted_o[1]),
        .bub_cnt   (bub_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            owed[u]    = 0;
            hlt_m[u]   = 1'b0;
            stall_m[u] = 1'b0;
            spm_m[u]   = 1'b0;
        end
    endtask

    // One clock edge of the reference behaviour for instance u.
    task automatic model_edge(input int u, input logic [19:0] ins, input bit ext);
        logic [4:0] opc;
        bit is_h, is_j, is_l;
        opc  = ins[19:15];
        is_h = ((opc & 5'b11110) == 5'b11110);
        is_j = ((opc & 5'b11110) == 5'b10100);
        is_l = (opc == 5'b10001);
        spm_m[u] = stall_m[u];
        if (hlt_m[u]) begin
            stall_m[u] = 1'b1;
        end else if (owed[u] > 0) begin
            // A bubble in progress: ext_stall freezes it, otherwise one bubble is paid.
            if (!ext) owed[u] = owed[u] - 1;
            stall_m[u] = (owed[u] > 0);
        end else if (ext) begin
            stall_m[u] = 1'b1;
        end else begin
            if (is_h)      hlt_m[u] = 1'b1;
            else if (is_j) owed[u]  = jb_p[u];
            else if (is_l) owed[u]  = lb_p[u];
            stall_m[u] = hlt_m[u] || (owed[u] > 0);
        end
    endtask

    task automatic check_outputs();
        for (int u = 0; u < 2; u++) begin
            check_val($sformatf("u%0d_stall", u),    32'(stall_o[u]),    32'(stall_m[u]));
            check_val($sformatf("u%0d_stall_pm", u), 32'(stall_pm_o[u]), 32'(spm_m[u]));
            check_val($sformatf("u%0d_halted", u),   32'(halted_o[u]),   32'(hlt_m[u]));
            check_val($sformatf("u%0d_bub_cnt", u),  32'(bub_o[u]),
                      (owed[u] > 0) ? 32'(owed[u] - 1) : 32'd0);
        end
    endtask

    task automatic step(input logic [19:0] i, input bit e);
        ins_pm    = i;
        ext_stall = e;
        @(posedge clk);
        model_edge(0, i, e);
        model_edge(1, i, e);
        #1;
        check_outputs();
    endtask

    // Reset asserted mid-cycle must clear outputs immediately, before any edge.
    task automatic mid_cycle_reset();
        #3;
        reset = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check_val($sformatf("u%0d_async_rst_stall", u),    32'(stall_o[u]),    32'd0);
            check_val($sformatf("u%0d_async_rst_stall_pm", u), 32'(stall_pm_o[u]), 32'd0);
            check_val($sformatf("u%0d_async_rst_halted", u),   32'(halted_o[u]),   32'd0);
            check_val($sformatf("u%0d_async_rst_bub", u),      32'(bub_o[u]),      32'd0);
        end
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        #3;
        reset = 1'b1;
    endtask

    function automatic logic [19:0] rand_ins();
        int r;
        r = $urandom_range(0, 15);
        if (r <= 3)       return 20'h00000;
        else if (r <= 6)  return 20'hA0000 | 20'($urandom_range(0, 32767));
        else if (r == 7)  return 20'hA8000;
        else if (r <= 10) return 20'h88000 | 20'($urandom_range(0, 32767));
        else if (r == 11) return ($urandom_range(0, 7) == 0) ? 20'hF0000 : 20'h00000;
        else              return 20'($urandom);
    endfunction

    initial begin
        jb_p[0] = 2; lb_p[0] = 1;
        jb_p[1] = 4; lb_p[1] = 0;
        reset     = 1'b0;
        ins_pm    = 20'h00000;
        ext_stall = 1'b0;
        model_reset();
        #6;
        reset = 1'b1;
        #1;
        check_outputs();

        // Idle
        for (int k = 0; k < 3; k++) dir_q.push_back('{20'h00000, 1'b0});
        // Jump for one clock
        dir_q.push_back('{20'hA0000, 1'b0});
        for (int k = 0; k < 5; k++) dir_q.push_back('{20'h00000, 1'b0});
        // Load, with a second load present on the exit edge
        for (int k = 0; k < 3; k++) dir_q.push_back('{20'h88000, 1'b0});
        for (int k = 0; k < 5; k++) dir_q.push_back('{20'h00000, 1'b0});
        // Jump, then ext_stall for 3 clocks while bub_cnt is 1
        dir_q.push_back('{20'hA0000, 1'b0});
        for (int k = 0; k < 3; k++) dir_q.push_back('{20'h00000, 1'b1});
        for (int k = 0; k < 5; k++) dir_q.push_back('{20'h00000, 1'b0});
        // Hazard word masked by ext_stall in IDLE
        dir_q.push_back('{20'hA0000, 1'b1});
        for (int k = 0; k < 5; k++) dir_q.push_back('{20'h00000, 1'b0});
        // Halt, then ext_stall toggling
        dir_q.push_back('{20'hF0000, 1'b0});
        for (int k = 0; k < 5; k++) dir_q.push_back('{20'h00000, 1'(k % 2)});

        foreach (dir_q[k]) step(dir_q[k].ins, dir_q[k].ext);
        mid_cycle_reset();

        for (int blk = 0; blk < 20; blk++) begin
            for (int k = 0; k < 50; k++) begin
                step(rand_ins(), ($urandom_range(0, 3) == 0));
            end
            mid_cycle_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
